// File: rtl/pc_gen_pkg.sv
// -----------------------------------------------------------------------------
// pc_gen_pkg
//   Shared definitions for the program-counter generator: default bus width,
//   default reset vector, instruction step sizes, the PC state machine
//   encoding and the target alignment rule.
// -----------------------------------------------------------------------------
package pc_gen_pkg;

  localparam int unsigned DATA_WIDTH           = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_1000;

  // Byte distance to the next sequential instruction.
  localparam int unsigned INSN_STEP_4 = 4;
  localparam int unsigned INSN_STEP_2 = 2;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_t;

  // With compressed instructions only halfword alignment is required;
  // otherwise targets must be word aligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb,
                                         input logic       c_ext);
    return c_ext ? addr_lsb[0] : (addr_lsb != 2'b00);
  endfunction

endpackage : pc_gen_pkg

// File: rtl/pc_gen_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//   Combinational next-PC selection for the RUN state. Priority, highest first:
//   trap redirect, aligned branch redirect, hold (stall or un-accepted fetch),
//   sequential increment. A misaligned branch is dropped and flagged.
//
// Ports
//   pc             current fetch PC
//   fetch_valid    fetch request currently presented
//   fetch_ready    instruction memory accepts the request this cycle
//   stall          hazard hold
//   fetch_is_c     instruction at pc is 16-bit (only honoured when C_EXT=1)
//   trap_valid     trap/mret redirect request, with trap_target
//   branch_valid   taken branch redirect request, with branch_target
//   next_pc        selected PC for the next cycle
//   redirect       a trap or aligned branch is being taken
//   misalign       branch request rejected because of target alignment
// -----------------------------------------------------------------------------
module pc_next_sel
  import pc_gen_pkg::is_misaligned, pc_gen_pkg::INSN_STEP_2, pc_gen_pkg::INSN_STEP_4;
#(
  parameter int unsigned DATA_WIDTH = pc_gen_pkg::DATA_WIDTH,
  parameter bit          C_EXT      = 1'b0
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  fetch_valid,
  input  logic                  fetch_ready,
  input  logic                  stall,
  input  logic                  fetch_is_c,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_target,
  input  logic                  branch_valid,
  input  logic [DATA_WIDTH-1:0] branch_target,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  redirect,
  output logic                  misalign
);

  logic                  branch_misaligned;
  logic                  branch_taken;
  logic                  hold;
  logic [DATA_WIDTH-1:0] step;

  // Trap targets are aligned by construction, so only branches are checked.
  assign branch_misaligned = is_misaligned(branch_target[1:0], C_EXT);

  // A branch only counts when no trap outranks it in the same cycle.
  assign branch_taken = branch_valid && !trap_valid && !branch_misaligned;
  assign misalign     = branch_valid && !trap_valid &&  branch_misaligned;
  assign redirect     = trap_valid || branch_taken;

  // An un-accepted request must stay on the bus until it is taken.
  assign hold = stall || (fetch_valid && !fetch_ready);

  assign step = (C_EXT && fetch_is_c) ? DATA_WIDTH'(INSN_STEP_2)
                                      : DATA_WIDTH'(INSN_STEP_4);

  always_comb begin
    // NOTE: defaulting every output first keeps this block free of latches.
    next_pc = pc;
    if (trap_valid) begin
      next_pc = trap_target;
    end else if (branch_valid) begin
      // Misaligned branches fall through to the held PC.
      if (!branch_misaligned) next_pc = branch_target;
    end else if (!hold) begin
      // Wraps modulo 2^DATA_WIDTH with no flag.
      next_pc = pc + step;
    end
  end

endmodule : pc_next_sel

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen
//   Program-counter generator at the head of the fetch stage. Holds the
//   BOOT/RUN/HALTED state machine, the PC register and the registered
//   misaligned-branch pulse. All outputs are flops; nothing combinational
//   reaches them from the inputs.
//
// Ports
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   stall          hazard hold; PC frozen unless redirected
//   fetch_ready    instruction memory accepts fetch_pc this cycle
//   fetch_is_c     instruction at fetch_pc is 16-bit (ignored when C_EXT=0)
//   branch_valid   taken branch request, branch_target its destination
//   trap_valid     trap/mret request, trap_target its destination
//   halt_req       debug halt request
//   resume_req     debug resume request
//   fetch_valid    fetch_pc is a live request (RUN state)
//   fetch_pc       current PC / instruction-memory address
//   misalign_err   one-cycle pulse after a dropped misaligned branch
//   halted         core in HALTED state
// -----------------------------------------------------------------------------
module pc_gen
  import pc_gen_pkg::pc_state_t, pc_gen_pkg::BOOT, pc_gen_pkg::RUN, pc_gen_pkg::HALTED;
#(
  parameter int unsigned          DATA_WIDTH   = pc_gen_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = DATA_WIDTH'(pc_gen_pkg::DEFAULT_RESET_VECTOR),
  parameter bit                   C_EXT        = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  fetch_ready,
  input  logic                  fetch_is_c,
  input  logic                  branch_valid,
  input  logic [DATA_WIDTH-1:0] branch_target,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_target,
  input  logic                  halt_req,
  input  logic                  resume_req,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  misalign_err,
  output logic                  halted
);

  pc_state_t             state;
  logic [DATA_WIDTH-1:0] sel_next_pc;
  logic                  sel_redirect;
  logic                  sel_misalign;
  logic                  halt_take;

  pc_next_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .C_EXT      (C_EXT)
  ) u_next_sel (
    .pc            (fetch_pc),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .stall         (stall),
    .fetch_is_c    (fetch_is_c),
    .trap_valid    (trap_valid),
    .trap_target   (trap_target),
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .next_pc       (sel_next_pc),
    .redirect      (sel_redirect),
    .misalign      (sel_misalign)
  );

  // Halting must not strand an outstanding request, unless a redirect
  // abandons that request anyway.
  assign halt_take = halt_req && (!(fetch_valid && !fetch_ready) || sel_redirect);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      fetch_pc     <= RESET_VECTOR;
      fetch_valid  <= 1'b0;
      misalign_err <= 1'b0;
      halted       <= 1'b0;
    end else begin
      misalign_err <= 1'b0;
      case (state)
        BOOT: begin
          // Single dead cycle; requests arriving now are ignored.
          state       <= RUN;
          fetch_valid <= 1'b1;
        end

        RUN: begin
          misalign_err <= sel_misalign;
          if (halt_take) begin
            state       <= HALTED;
            fetch_valid <= 1'b0;
            halted      <= 1'b1;
            // Freeze at the current PC so resume refetches it, but still
            // honour a redirect that coincides with the halt.
            if (sel_redirect) fetch_pc <= sel_next_pc;
          end else begin
            fetch_pc <= sel_next_pc;
          end
        end

        HALTED: begin
          // Branches are ignored here; a trap doubles as a resume.
          if (trap_valid || resume_req) begin
            state       <= RUN;
            fetch_valid <= 1'b1;
            halted      <= 1'b0;
            if (trap_valid) fetch_pc <= trap_target;
          end
        end

        default: begin
          state       <= BOOT;
          fetch_valid <= 1'b0;
          halted      <= 1'b0;
        end
      endcase
    end
  end

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen
//   Two pc_gen instances (C_EXT=0 and C_EXT=1) share one set of inputs.
//   Directed scenario tables cover the documented cases; a randomized phase is
//   compared against a behavioural model of the PC rules.
// -----------------------------------------------------------------------------
module tb_pc_gen;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, fetch_ready, fetch_is_c;
  logic        branch_valid, trap_valid, halt_req, resume_req;
  logic [31:0] branch_target, trap_target;

  // Index 0: C_EXT=0, index 1: C_EXT=1.
  logic        fv  [2];
  logic        hl  [2];
  logic        err [2];
  logic [31:0] pc  [2];

  int n_vec  = 0;
  int n_miss = 0;

  // Stimulus row plus the state expected after the following clock edge.
  typedef struct packed {
    logic        rst, stall, ready, is_c;
    logic        bv;
    logic [31:0] bt;
    logic        tv;
    logic [31:0] tt;
    logic        halt, resume;
    logic [31:0] pc0, pc1;
    logic        fv, hl, err0, err1;
  } row_t;

  pc_gen #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_is_c(fetch_is_c), .branch_valid(branch_valid), .branch_target(branch_target),
    .trap_valid(trap_valid), .trap_target(trap_target), .halt_req(halt_req),
    .resume_req(resume_req), .fetch_valid(fv[0]), .fetch_pc(pc[0]),
    .misalign_err(err[0]), .halted(hl[0])
  );

  pc_gen #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .fetch_is_c(fetch_is_c), .branch_valid(branch_valid), .branch_target(branch_target),
    .trap_valid(trap_valid), .trap_target(trap_target), .halt_req(halt_req),
    .resume_req(resume_req), .fetch_valid(fv[1]), .fetch_pc(pc[1]),
    .misalign_err(err[1]), .halted(hl[1])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input row_t r);
    rst           = r.rst;
    stall         = r.stall;
    fetch_ready   = r.ready;
    fetch_is_c    = r.is_c;
    branch_valid  = r.bv;
    branch_target = r.bt;
    trap_valid    = r.tv;
    trap_target   = r.tt;
    halt_req      = r.halt;
    resume_req    = r.resume;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    row_t t [4];
    t[0] = '{Y,N,Y,N, N,32'h0, N,32'h0, N,N, 32'h1000,32'h1000, N,N,N,N};
    t[1] = '{N,N,Y,N, N,32'h0, N,32'h0, N,N, 32'h1000,32'h1000, Y,N,N,N};
    t[2] = '{N,N,Y,N, N,32'h0, N,32'h0, N,N, 32'h1004,32'h1004, Y,N,N,N};
    t[3] = '{N,N,Y,N, N,32'h0, N,32'h0, N,N, 32'h1008,32'h1008, Y,N,N,N};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] want_pc;
        logic        want_err;
        want_pc  = (k == 0) ? t[i].pc0  : t[i].pc1;
        want_err = (k == 0) ? t[i].err0 : t[i].err1;
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {want_pc, t[i].fv, t[i].hl, want_err}) begin
          n_miss++;
          $display("FAIL reset row %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   i, k, pc[k], fv[k], hl[k], err[k], want_pc, t[i].fv, t[i].hl, want_err);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_stall_hold();
    row_t t [6];
    t[0] = '{N,N,N,N, N,32'h0, N,32'h0, N,N, 32'h1008,32'h1008, Y,N,N,N};
    t[1] = '{N,N,N,N, N,32'h0, N,32'h0, N,N, 32'h1008,32'h1008, Y,N,N,N};
    t[2] = '{N,N,N,N, N,32'h0, N,32'h0, N,N, 32'h1008,32'h1008, Y,N,N,N};
    t[3] = '{N,Y,Y,N, N,32'h0, N,32'h0, N,N, 32'h1008,32'h1008, Y,N,N,N};
    t[4] = '{N,Y,Y,N, N,32'h0, N,32'h0, N,N, 32'h1008,32'h1008, Y,N,N,N};
    t[5] = '{N,N,Y,N, N,32'h0, N,32'h0, N,N, 32'h100C,32'h100C, Y,N,N,N};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] want_pc;
        logic        want_err;
        want_pc  = (k == 0) ? t[i].pc0  : t[i].pc1;
        want_err = (k == 0) ? t[i].err0 : t[i].err1;
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {want_pc, t[i].fv, t[i].hl, want_err}) begin
          n_miss++;
          $display("FAIL stall_hold row %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   i, k, pc[k], fv[k], hl[k], err[k], want_pc, t[i].fv, t[i].hl, want_err);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_halt_resume();
    row_t t [11];
    t[0]  = '{N,N,Y,N, N,32'h0,    N,32'h0,    Y,N, 32'h100C,32'h100C, N,Y,N,N};
    t[1]  = '{N,N,Y,N, Y,32'h3000, N,32'h0,    N,N, 32'h100C,32'h100C, N,Y,N,N};
    t[2]  = '{N,N,Y,N, Y,32'h3002, N,32'h0,    N,N, 32'h100C,32'h100C, N,Y,N,N};
    t[3]  = '{N,N,Y,N, N,32'h0,    N,32'h0,    N,Y, 32'h100C,32'h100C, Y,N,N,N};
    t[4]  = '{N,N,Y,N, N,32'h0,    N,32'h0,    N,N, 32'h1010,32'h1010, Y,N,N,N};
    t[5]  = '{N,N,N,N, N,32'h0,    N,32'h0,    Y,N, 32'h1010,32'h1010, Y,N,N,N};
    t[6]  = '{N,N,N,N, Y,32'h5000, N,32'h0,    Y,N, 32'h5000,32'h5000, N,Y,N,N};
    t[7]  = '{N,N,Y,N, N,32'h0,    N,32'h0,    Y,Y, 32'h5000,32'h5000, Y,N,N,N};
    t[8]  = '{N,N,Y,N, N,32'h0,    N,32'h0,    Y,Y, 32'h5000,32'h5000, N,Y,N,N};
    t[9]  = '{N,N,Y,N, N,32'h0,    Y,32'h6000, N,N, 32'h6000,32'h6000, Y,N,N,N};
    t[10] = '{N,N,Y,N, N,32'h0,    N,32'h0,    N,N, 32'h6004,32'h6004, Y,N,N,N};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] want_pc;
        logic        want_err;
        want_pc  = (k == 0) ? t[i].pc0  : t[i].pc1;
        want_err = (k == 0) ? t[i].err0 : t[i].err1;
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {want_pc, t[i].fv, t[i].hl, want_err}) begin
          n_miss++;
          $display("FAIL halt_resume row %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   i, k, pc[k], fv[k], hl[k], err[k], want_pc, t[i].fv, t[i].hl, want_err);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_redirect_priority();
    row_t t [2];
    t[0] = '{N,Y,N,N, Y,32'h2000, Y,32'h8000_0000, N,N, 32'h8000_0000,32'h8000_0000, Y,N,N,N};
    t[1] = '{N,N,N,N, Y,32'h2003, Y,32'h8000_0010, N,N, 32'h8000_0010,32'h8000_0010, Y,N,N,N};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] want_pc;
        logic        want_err;
        want_pc  = (k == 0) ? t[i].pc0  : t[i].pc1;
        want_err = (k == 0) ? t[i].err0 : t[i].err1;
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {want_pc, t[i].fv, t[i].hl, want_err}) begin
          n_miss++;
          $display("FAIL redirect_priority row %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   i, k, pc[k], fv[k], hl[k], err[k], want_pc, t[i].fv, t[i].hl, want_err);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_misalign();
    row_t t [5];
    t[0] = '{N,N,Y,N, Y,32'h2002, N,32'h0, N,N, 32'h8000_0010,32'h2002, Y,N,Y,N};
    t[1] = '{N,N,Y,Y, N,32'h0,    N,32'h0, N,N, 32'h8000_0014,32'h2004, Y,N,N,N};
    t[2] = '{N,N,Y,N, Y,32'h2001, N,32'h0, N,N, 32'h8000_0014,32'h2004, Y,N,Y,Y};
    t[3] = '{N,N,N,N, Y,32'h2001, N,32'h0, N,N, 32'h8000_0014,32'h2004, Y,N,Y,Y};
    t[4] = '{N,N,Y,N, N,32'h0,    N,32'h0, N,N, 32'h8000_0018,32'h2008, Y,N,N,N};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] want_pc;
        logic        want_err;
        want_pc  = (k == 0) ? t[i].pc0  : t[i].pc1;
        want_err = (k == 0) ? t[i].err0 : t[i].err1;
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {want_pc, t[i].fv, t[i].hl, want_err}) begin
          n_miss++;
          $display("FAIL misalign row %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   i, k, pc[k], fv[k], hl[k], err[k], want_pc, t[i].fv, t[i].hl, want_err);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_wrap();
    row_t t [3];
    t[0] = '{N,N,Y,N, N,32'h0, Y,32'hFFFF_FFFC, N,N, 32'hFFFF_FFFC,32'hFFFF_FFFC, Y,N,N,N};
    t[1] = '{N,N,Y,N, N,32'h0, N,32'h0,         N,N, 32'h0000_0000,32'h0000_0000, Y,N,N,N};
    t[2] = '{N,N,Y,Y, N,32'h0, N,32'h0,         N,N, 32'h0000_0004,32'h0000_0002, Y,N,N,N};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] want_pc;
        logic        want_err;
        want_pc  = (k == 0) ? t[i].pc0  : t[i].pc1;
        want_err = (k == 0) ? t[i].err0 : t[i].err1;
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {want_pc, t[i].fv, t[i].hl, want_err}) begin
          n_miss++;
          $display("FAIL wrap row %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   i, k, pc[k], fv[k], hl[k], err[k], want_pc, t[i].fv, t[i].hl, want_err);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_op();
    row_t t [7];
    t[0] = '{N,Y,Y,N, N,32'h0,    N,32'h0,    N,N, 32'h0004,32'h0002, Y,N,N,N};
    t[1] = '{Y,Y,Y,N, N,32'h0,    N,32'h0,    N,N, 32'h1000,32'h1000, N,N,N,N};
    t[2] = '{N,N,Y,N, N,32'h0,    N,32'h0,    N,N, 32'h1000,32'h1000, Y,N,N,N};
    t[3] = '{N,N,Y,N, N,32'h0,    N,32'h0,    Y,N, 32'h1000,32'h1000, N,Y,N,N};
    t[4] = '{Y,N,Y,N, N,32'h0,    N,32'h0,    Y,N, 32'h1000,32'h1000, N,N,N,N};
    t[5] = '{N,N,Y,N, Y,32'h7002, Y,32'h7000, N,N, 32'h1000,32'h1000, Y,N,N,N};
    t[6] = '{N,N,Y,N, N,32'h0,    N,32'h0,    N,N, 32'h1004,32'h1004, Y,N,N,N};
    foreach (t[i]) begin
      drive(t[i]);
      tick();
      for (int k = 0; k < 2; k++) begin
        logic [31:0] want_pc;
        logic        want_err;
        want_pc  = (k == 0) ? t[i].pc0  : t[i].pc1;
        want_err = (k == 0) ? t[i].err0 : t[i].err1;
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {want_pc, t[i].fv, t[i].hl, want_err}) begin
          n_miss++;
          $display("FAIL reset_mid_op row %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   i, k, pc[k], fv[k], hl[k], err[k], want_pc, t[i].fv, t[i].hl, want_err);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Randomized phase against a behavioural model: mode 0 = booting,
  // 1 = running, 2 = halted; PC arithmetic in plain 32-bit integers.
  task automatic test_random();
    int          mode [2];
    logic [31:0] m_pc [2];
    logic        m_err[2];
    mode  = '{0, 0};
    m_pc  = '{32'h1000, 32'h1000};
    m_err = '{1'b0, 1'b0};
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst           = (cyc == 0) || ($urandom_range(0, 99) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      fetch_ready   = ($urandom_range(0, 3) != 0);
      fetch_is_c    = 1'($urandom_range(0, 1));
      trap_valid    = ($urandom_range(0, 11) == 0);
      trap_target   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      branch_valid  = ($urandom_range(0, 5) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 1) == 0) branch_target[1:0] = 2'b00;
      halt_req      = ($urandom_range(0, 9) == 0);
      resume_req    = ($urandom_range(0, 4) == 0);

      for (int k = 0; k < 2; k++) begin
        int unsigned align;
        int unsigned step;
        logic [31:0] target;
        logic        redir;
        align = (k == 1) ? 2 : 4;
        step  = (k == 1 && fetch_is_c) ? 2 : 4;
        m_err[k] = 1'b0;
        if (rst) begin
          mode[k] = 0;
          m_pc[k] = 32'h1000;
        end else if (mode[k] == 0) begin
          mode[k] = 1;
        end else if (mode[k] == 1) begin
          target = m_pc[k];
          redir  = 1'b0;
          if (trap_valid) begin
            target = trap_target;
            redir  = 1'b1;
          end else if (branch_valid) begin
            if (branch_target % align != 0) m_err[k] = 1'b1;
            else begin
              target = branch_target;
              redir  = 1'b1;
            end
          end else if (!stall && fetch_ready) begin
            target = m_pc[k] + step;
          end
          if (halt_req && (fetch_ready || redir)) begin
            mode[k] = 2;
            if (redir) m_pc[k] = target;
          end else begin
            m_pc[k] = target;
          end
        end else begin
          if (trap_valid) begin
            mode[k] = 1;
            m_pc[k] = trap_target;
          end else if (resume_req) begin
            mode[k] = 1;
          end
        end
      end

      tick();

      for (int k = 0; k < 2; k++) begin
        logic want_fv;
        logic want_hl;
        want_fv = (mode[k] == 1);
        want_hl = (mode[k] == 2);
        n_vec++;
        if ({pc[k], fv[k], hl[k], err[k]} !== {m_pc[k], want_fv, want_hl, m_err[k]}) begin
          n_miss++;
          $display("FAIL random cycle %0d c_ext=%0d: pc=%h valid=%b halted=%b err=%b, want pc=%h valid=%b halted=%b err=%b",
                   cyc, k, pc[k], fv[k], hl[k], err[k], m_pc[k], want_fv, want_hl, m_err[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_stall_hold();
    test_halt_resume();
    test_redirect_priority();
    test_misalign();
    test_wrap();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_pc_gen
